// File: rtl/csr_pkg.sv
// Shared CSR definitions: counter CSR addresses and counter reset constants.
package csr_pkg;

    localparam int CSR_ADDR_W = 12;

    // Machine-mode counter addresses (read/write)
    localparam logic [CSR_ADDR_W-1:0] MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] MINSTRETH = 12'hB82;

    // User-mode read-only aliases of the machine counters
    localparam logic [CSR_ADDR_W-1:0] CYCLE     = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] INSTRET   = 12'hC02;
    localparam logic [CSR_ADDR_W-1:0] CYCLEH    = 12'hC80;
    localparam logic [CSR_ADDR_W-1:0] INSTRETH  = 12'hC82;

    // Default reset value for 64-bit counters, shared by other CSR blocks
    localparam logic [63:0] COUNTER_RESET_ZERO = 64'h0;

    // True when the address is one of the user aliases, which must never be written
    function automatic logic is_user_alias(input logic [CSR_ADDR_W-1:0] addr);
        return (addr == CYCLE) || (addr == INSTRET) ||
               (addr == CYCLEH) || (addr == INSTRETH);
    endfunction

endpackage

// File: rtl/counter64.sv
// 64-bit counter with independently loadable 32-bit halves and an increment enable.
// Loads take priority over the increment; load_lo takes priority over load_hi.
module counter64 #(
    parameter logic [63:0] RESET_VALUE = 64'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic        inc,
    input  logic [31:0] load_data,
    output logic [63:0] count_out
);

    logic [63:0] count_q;

    // Update the counter: a half load freezes the count for that cycle, else step by one
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q <= RESET_VALUE;
        end else if (load_lo) begin
            count_q <= {count_q[63:32], load_data};
        end else if (load_hi) begin
            count_q <= {load_data, count_q[31:0]};
        end else if (inc) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/machine_counters.sv
// Machine performance counters mcycle/minstret with CSR read/write access
// and decoding of the read-only user aliases cycle/instret.
module machine_counters
    import csr_pkg::*;
#(
    parameter logic [63:0] MCYCLE_RESET   = COUNTER_RESET_ZERO,
    parameter logic [63:0] MINSTRET_RESET = COUNTER_RESET_ZERO
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_en_in,
    input  logic [11:0] csr_addr_in,
    input  logic [31:0] data_wr_in,
    input  logic        instret_inc_in,
    input  logic        mcountinhibit_cy_in,
    input  logic        mcountinhibit_ir_in,
    output logic [31:0] data_rd_out,
    output logic        addr_hit_out,
    output logic        ill_wr_out,
    output logic [63:0] mcycle_out,
    output logic [63:0] minstret_out
);

    logic        cy_load_lo;
    logic        cy_load_hi;
    logic        cy_inc;
    logic        ir_load_lo;
    logic        ir_load_hi;
    logic        ir_inc;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    // Only the machine-mode addresses load the counters; alias writes do nothing
    assign cy_load_lo = wr_en_in && (csr_addr_in == MCYCLE);
    assign cy_load_hi = wr_en_in && (csr_addr_in == MCYCLEH);
    assign ir_load_lo = wr_en_in && (csr_addr_in == MINSTRET);
    assign ir_load_hi = wr_en_in && (csr_addr_in == MINSTRETH);

    // Inhibit bits are used as presented this cycle
    assign cy_inc = !mcountinhibit_cy_in;
    assign ir_inc = !mcountinhibit_ir_in && instret_inc_in;

    counter64 #(
        .RESET_VALUE (MCYCLE_RESET)
    ) u_cycle (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_lo   (cy_load_lo),
        .load_hi   (cy_load_hi),
        .inc       (cy_inc),
        .load_data (data_wr_in),
        .count_out (mcycle)
    );

    counter64 #(
        .RESET_VALUE (MINSTRET_RESET)
    ) u_instret (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_lo   (ir_load_lo),
        .load_hi   (ir_load_hi),
        .inc       (ir_inc),
        .load_data (data_wr_in),
        .count_out (minstret)
    );

    // Read mux over the current (pre-update) counter values, plus address-hit decode
    always_comb begin
        data_rd_out  = 32'h0;
        addr_hit_out = 1'b0;
        unique case (csr_addr_in)
            MCYCLE, CYCLE: begin
                data_rd_out  = mcycle[31:0];
                addr_hit_out = 1'b1;
            end
            MCYCLEH, CYCLEH: begin
                data_rd_out  = mcycle[63:32];
                addr_hit_out = 1'b1;
            end
            MINSTRET, INSTRET: begin
                data_rd_out  = minstret[31:0];
                addr_hit_out = 1'b1;
            end
            MINSTRETH, INSTRETH: begin
                data_rd_out  = minstret[63:32];
                addr_hit_out = 1'b1;
            end
            default: begin
                data_rd_out  = 32'h0;
                addr_hit_out = 1'b0;
            end
        endcase
    end

    assign ill_wr_out   = wr_en_in && is_user_alias(csr_addr_in);
    assign mcycle_out   = mcycle;
    assign minstret_out = minstret;

endmodule

// File: tb/tb_machine_counters.sv
// Directed self-checking bench for machine_counters.
// Inputs change and outputs are sampled around the falling edge, away from the active edge.
module tb_machine_counters;

    logic        clk_in;
    logic        rst_in;
    logic        wr_en_in;
    logic [11:0] csr_addr_in;
    logic [31:0] data_wr_in;
    logic        instret_inc_in;
    logic        mcountinhibit_cy_in;
    logic        mcountinhibit_ir_in;
    logic [31:0] data_rd_out;
    logic        addr_hit_out;
    logic        ill_wr_out;
    logic [63:0] mcycle_out;
    logic [63:0] minstret_out;

    int errors;
    int checks;

    machine_counters dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .wr_en_in            (wr_en_in),
        .csr_addr_in         (csr_addr_in),
        .data_wr_in          (data_wr_in),
        .instret_inc_in      (instret_inc_in),
        .mcountinhibit_cy_in (mcountinhibit_cy_in),
        .mcountinhibit_ir_in (mcountinhibit_ir_in),
        .data_rd_out         (data_rd_out),
        .addr_hit_out        (addr_hit_out),
        .ill_wr_out          (ill_wr_out),
        .mcycle_out          (mcycle_out),
        .minstret_out        (minstret_out)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        wr_en_in    = 1'b1;
        csr_addr_in = addr;
        data_wr_in  = data;
    endtask

    // Directed sequence with hand-computed expectations
    initial begin
        errors              = 0;
        checks              = 0;
        rst_in              = 1'b0;
        wr_en_in            = 1'b0;
        csr_addr_in         = 12'h000;
        data_wr_in          = 32'h0;
        instret_inc_in      = 1'b0;
        mcountinhibit_cy_in = 1'b0;
        mcountinhibit_ir_in = 1'b0;

        // Reset state
        #2;
        check("reset_mcycle", mcycle_out, 64'h0);
        check("reset_minstret", minstret_out, 64'h0);
        check("reset_rd", {32'h0, data_rd_out}, 64'h0);
        check("reset_hit", {63'h0, addr_hit_out}, 64'h0);
        check("reset_ill", {63'h0, ill_wr_out}, 64'h0);

        // 1: ten free-running cycles
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (10) @(negedge clk_in);
        check("run10_mcycle", mcycle_out, 64'd10);
        check("run10_minstret", minstret_out, 64'd0);
        csr_addr_in = 12'hB00;
        #1;
        check("rd_mcycle", {32'h0, data_rd_out}, 64'd10);
        check("rd_mcycle_hit", {63'h0, addr_hit_out}, 64'd1);

        // 2: carry from low into high half; read during write returns old value
        csr_write(12'hB00, 32'hFFFF_FFFE);
        #1;
        check("rd_during_wr", {32'h0, data_rd_out}, 64'd10);
        @(negedge clk_in);
        check("wr_lo", mcycle_out, 64'h0000_0000_FFFF_FFFE);
        csr_write(12'hB80, 32'h0);
        @(negedge clk_in);
        check("wr_hi", mcycle_out, 64'h0000_0000_FFFF_FFFE);
        wr_en_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("carry", mcycle_out, 64'h0000_0001_0000_0001);
        csr_addr_in = 12'hB80;
        #1;
        check("rd_mcycleh", {32'h0, data_rd_out}, 64'd1);
        csr_addr_in = 12'hC80;
        #1;
        check("rd_cycleh", {32'h0, data_rd_out}, 64'd1);

        // 3: 64-bit wrap, then inhibit freezes mcycle
        csr_write(12'hB00, 32'hFFFF_FFFF);
        @(negedge clk_in);
        csr_write(12'hB80, 32'hFFFF_FFFF);
        @(negedge clk_in);
        check("all_ones", mcycle_out, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_en_in = 1'b0;
        @(negedge clk_in);
        check("wrap", mcycle_out, 64'h0);
        mcountinhibit_cy_in = 1'b1;
        repeat (5) @(negedge clk_in);
        check("inhibit_cy", mcycle_out, 64'h0);
        check("minstret_idle", minstret_out, 64'h0);

        // 4: retire pulses with inhibit on the third cycle, then write beats increment
        mcountinhibit_cy_in = 1'b0;
        instret_inc_in      = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        mcountinhibit_ir_in = 1'b1;
        @(negedge clk_in);
        mcountinhibit_ir_in = 1'b0;
        @(negedge clk_in);
        check("instret_3", minstret_out, 64'd3);
        csr_write(12'hB02, 32'h100);
        @(negedge clk_in);
        check("wr_wins_lo", minstret_out, 64'h100);
        check("mcycle_5", mcycle_out, 64'd5);
        csr_write(12'hB82, 32'h2);
        @(negedge clk_in);
        check("wr_wins_hi", minstret_out, 64'h0000_0002_0000_0100);
        wr_en_in       = 1'b0;
        instret_inc_in = 1'b0;

        // 5: writes to read-only aliases, unmapped address
        csr_write(12'hC00, 32'hDEAD);
        #1;
        check("ill_cycle", {63'h0, ill_wr_out}, 64'd1);
        check("rd_cycle", {32'h0, data_rd_out}, 64'd6);
        @(negedge clk_in);
        check("ill_no_effect", mcycle_out, 64'd7);
        csr_write(12'hC82, 32'hFFFF_FFFF);
        #1;
        check("ill_instreth", {63'h0, ill_wr_out}, 64'd1);
        @(negedge clk_in);
        check("ill_instreth_state", minstret_out, 64'h0000_0002_0000_0100);
        csr_write(12'h7C0, 32'h1);
        #1;
        check("unmapped_rd", {32'h0, data_rd_out}, 64'd0);
        check("unmapped_hit", {63'h0, addr_hit_out}, 64'd0);
        check("unmapped_ill", {63'h0, ill_wr_out}, 64'd0);
        wr_en_in = 1'b0;
        #1;
        csr_addr_in = 12'hC00;
        #1;
        check("ill_clear", {63'h0, ill_wr_out}, 64'd0);

        // 6: asynchronous reset between edges, held across an edge with a pending write
        @(negedge clk_in);
        instret_inc_in = 1'b1;
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_mcycle", mcycle_out, 64'h0);
        check("async_minstret", minstret_out, 64'h0);
        csr_write(12'hB00, 32'h1234);
        @(negedge clk_in);
        check("held_mcycle", mcycle_out, 64'h0);
        wr_en_in = 1'b0;
        rst_in   = 1'b1;
        @(negedge clk_in);
        check("post_reset", mcycle_out, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
